// File: rtl/tinyqv_fetch_aligner.sv
// ---------------------------------------------------------------------------
// tinyqv_fetch_aligner
//
// Purpose:
//   Sits between the QSPI instruction fetch path and the TinyQV decoder.
//   Buffers an in-order stream of 16-bit halfwords in a small circular buffer
//   and presents one complete, right-aligned instruction (16-bit compressed or
//   32-bit) with its halfword PC. A 32-bit instruction whose halves arrive in
//   separate fetches is held until both halves are buffered. A flush drops
//   everything buffered and restarts the PC at new_pc.
//
// Ports:
//   clk          sole clock, rising edge
//   rstn         asynchronous active-low reset
//   in_data      next sequential halfword from fetch
//   in_valid     in_data valid
//   in_ready     buffer has room; halfword taken when in_valid && in_ready
//   flush        discard buffered halfwords, restart at new_pc
//   new_pc       halfword address of first halfword after a flush
//   instr        instruction; 16-bit instructions in [15:0], [31:16] = 0
//   instr_len    2'b01 = 16-bit, 2'b10 = 32-bit
//   instr_pc     halfword address of instr[15:0]
//   instr_valid  instr / instr_len / instr_pc valid
//   instr_ready  consumer takes instruction when instr_valid && instr_ready
//
// Configuration:
//   TINYQV_FETCH_BYPASS_EN  when defined, an incoming halfword may complete
//                           an instruction combinationally in the same cycle
//                           (empty buffer + 16-bit halfword, or a lone
//                           32-bit head + its upper half). Undefined: outputs
//                           depend on registered state only.
// ---------------------------------------------------------------------------
module tinyqv_fetch_aligner #(
   parameter int DEPTH_HW  = 4,
   parameter int ADDR_BITS = 24
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [15:0]          in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   input  logic [ADDR_BITS-2:0] new_pc,
   output logic [31:0]          instr,
   output logic [1:0]           instr_len,
   output logic [ADDR_BITS-2:0] instr_pc,
   output logic                 instr_valid,
   input  logic                 instr_ready
);

   localparam int PTR_W = $clog2(DEPTH_HW);
   localparam int CNT_W = PTR_W + 1;
   localparam int PC_W  = ADDR_BITS - 1;

   logic [15:0]      buf_mem [DEPTH_HW];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [PC_W-1:0]  pc_reg;

   logic [15:0] head_hw;
   logic [15:0] next_hw;
   logic        head_is_32;
   logic        buf_valid;
   logic [1:0]  buf_len;
   logic [31:0] buf_instr;

   logic        do_push;
   logic [1:0]  buf_pop;   // halfwords removed from the buffer this edge
   logic [1:0]  pc_adv;    // halfwords retired this edge (may exceed buf_pop with bypass)

   assign head_hw    = buf_mem[rd_ptr_reg];
   assign next_hw    = buf_mem[rd_ptr_reg + PTR_W'(1)];
   assign head_is_32 = (head_hw[1:0] == 2'b11);

   // The count qualifiers come first so an unwritten (empty) head never
   // leaks onto the outputs.
   assign buf_valid = (count_reg >= CNT_W'(2)) ||
                      ((count_reg != '0) && !head_is_32);
   assign buf_len   = ((count_reg != '0) && head_is_32) ? 2'b10 : 2'b01;
   assign buf_instr = head_is_32 ? {next_hw, head_hw} : {16'h0000, head_hw};

   always_comb begin
      in_ready    = (count_reg < CNT_W'(DEPTH_HW));
      instr_valid = buf_valid;
      instr       = buf_valid ? buf_instr : 32'h0000_0000;
      instr_len   = buf_len;
      instr_pc    = pc_reg;
      do_push     = in_valid && in_ready && !flush;
      buf_pop     = (buf_valid && instr_ready && !flush) ? buf_len : 2'd0;
      pc_adv      = buf_pop;
`ifdef TINYQV_FETCH_BYPASS_EN
      if (in_valid && !flush) begin
         if ((count_reg == '0) && (in_data[1:0] != 2'b11)) begin
            instr_valid = 1'b1;
            instr       = {16'h0000, in_data};
            instr_len   = 2'b01;
            if (instr_ready) begin
               // Consumed straight from the input; never written.
               do_push = 1'b0;
               pc_adv  = 2'd1;
            end
         end else if ((count_reg == CNT_W'(1)) && head_is_32) begin
            instr_valid = 1'b1;
            instr       = {in_data, head_hw};
            instr_len   = 2'b10;
            if (instr_ready) begin
               // Lower half leaves the buffer, upper half is never written.
               do_push = 1'b0;
               buf_pop = 2'd1;
               pc_adv  = 2'd2;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         pc_reg     <= '0;
      end else if (flush) begin
         count_reg  <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         pc_reg     <= new_pc;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         // Pointers and pc are sized so the additions wrap naturally.
         rd_ptr_reg <= rd_ptr_reg + PTR_W'(buf_pop);
         pc_reg     <= pc_reg + PC_W'(pc_adv);
         count_reg  <= count_reg + CNT_W'(do_push) - CNT_W'(buf_pop);
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         buf_mem[wr_ptr_reg] <= in_data;
      end
   end

endmodule
